// File: rtl/mux4_1_rr.sv
// 4:1 round-robin merging multiplexer with one registered output stage.
// Optional packet locking is enabled by defining MUX4_PKT_LOCK_EN.
module mux4_1_rr #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*WIDTH-1:0]   X,
    input  logic [3:0]           x_valid,
    output logic [3:0]           x_ready,
    input  logic [3:0]           x_last,
    output logic [WIDTH-1:0]     Y,
    output logic [1:0]           sel,
    output logic                 y_valid,
    input  logic                 y_ready
);

    logic [WIDTH-1:0] ch_data [4];
    logic [1:0]       cand    [4];

    logic [1:0]       ptr_q;
    logic [WIDTH-1:0] y_q;
    logic [1:0]       sel_q;
    logic             y_valid_q;

    logic             load;
    logic [1:0]       rr_grant;
    logic             rr_found;
    logic [1:0]       grant;
    logic             grant_valid;

    // cand[k] is the channel examined at priority rank k (ptr+1 first, ptr last)
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_chan
            assign ch_data[gi] = X[gi*WIDTH +: WIDTH];
            assign cand[gi]    = ptr_q + 2'(gi + 1);
            assign x_ready[gi] = !rst && load && grant_valid && (grant == 2'(gi));
        end
    endgenerate

    assign load = !y_valid_q || y_ready;

    always_comb begin
        rr_grant = ptr_q;
        rr_found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!rr_found && x_valid[cand[k]]) begin
                rr_grant = cand[k];
                rr_found = 1'b1;
            end
        end
    end

`ifdef MUX4_PKT_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t     state_q;
    logic [1:0] lock_ch_q;

    // While a packet is open only its channel may advance, even if it stalls
    always_comb begin
        if (state_q == LOCKED) begin
            grant       = lock_ch_q;
            grant_valid = x_valid[lock_ch_q];
        end else begin
            grant       = rr_grant;
            grant_valid = rr_found;
        end
    end
`else
    logic unused_x_last;

    assign unused_x_last = ^x_last;
    assign grant         = rr_grant;
    assign grant_valid   = rr_found;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            sel_q     <= 2'd0;
            y_valid_q <= 1'b0;
            ptr_q     <= 2'd3;
`ifdef MUX4_PKT_LOCK_EN
            state_q   <= IDLE;
            lock_ch_q <= 2'd0;
`endif
        end else if (load) begin
            if (grant_valid) begin
                y_q       <= ch_data[grant];
                sel_q     <= grant;
                y_valid_q <= 1'b1;
                ptr_q     <= grant;
`ifdef MUX4_PKT_LOCK_EN
                case (state_q)
                    IDLE: begin
                        if (!x_last[grant]) begin
                            state_q   <= LOCKED;
                            lock_ch_q <= grant;
                        end
                    end
                    LOCKED: begin
                        if (x_last[lock_ch_q]) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
`endif
            end else begin
                y_valid_q <= 1'b0;
            end
        end
    end

    assign Y       = y_q;
    assign sel     = sel_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_mux4_1_rr.sv
// Self-checking bench for mux4_1_rr: a queue-free behavioural model checked every
// cycle, plus directed literal expectations; packet test runs when MUX4_PKT_LOCK_EN is set.
module tb_mux4_1_rr;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] X = 4'b0;
    logic [3:0] x_valid = 4'b0;
    logic [3:0] x_ready;
    logic [3:0] x_last = 4'b1111;
    logic [0:0] Y;
    logic [1:0] sel;
    logic       y_valid;
    logic       y_ready = 1'b1;

    int pass_cnt = 0;
    int total_cnt = 0;

    mux4_1_rr #(.WIDTH(1)) dut (
        .clk     (clk),
        .rst     (rst),
        .X       (X),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .x_last  (x_last),
        .Y       (Y),
        .sel     (sel),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit model_ok = 1'b0;
    int m_ptr = 3;
    int m_y = 0;
    int m_sel = 0;
    bit m_vld = 1'b0;
    bit m_locked = 1'b0;
    int m_lock = 0;

    function automatic int m_grant(input logic [3:0] v);
        int c;
        if (m_locked) return v[m_lock] ? m_lock : -1;
        for (int k = 1; k <= 4; k++) begin
            c = (m_ptr + k) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic int m_ready(input logic [3:0] v, input logic r, input logic yr);
        int g;
        g = m_grant(v);
        if (r) return 0;
        if ((!m_vld || yr) && g >= 0) return 1 << g;
        return 0;
    endfunction

    always @(posedge clk) begin
        int g;
        if (rst) begin
            m_vld = 1'b0; m_y = 0; m_sel = 0; m_ptr = 3; m_locked = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (m_vld && y_ready)
                $display("beat: sel=%0d Y=%0d t=%0t", m_sel, m_y, $time);
            if (!m_vld || y_ready) begin
                g = m_grant(x_valid);
                if (g >= 0) begin
`ifdef MUX4_PKT_LOCK_EN
                    if (!m_locked && !x_last[g]) begin
                        m_locked = 1'b1; m_lock = g;
                    end else if (m_locked && x_last[g]) begin
                        m_locked = 1'b0;
                    end
`endif
                    m_y = int'(X[g]); m_sel = g; m_vld = 1'b1; m_ptr = g;
                end else begin
                    m_vld = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_y_valid", int'(y_valid), int'(m_vld));
            chk("model_Y", int'(Y), m_y);
            chk("model_sel", int'(sel), m_sel);
            chk("model_x_ready", int'(x_ready), m_ready(x_valid, rst, y_ready));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [8:0] vec [12];
    logic [1:0] exp_sel [8];
    logic       exp_y   [8];

    initial begin
        vec = '{9'b0000_0000_1, 9'b0011_0001_1, 9'b0011_0010_0, 9'b0011_0011_1,
                9'b1000_1000_0, 9'b0100_0100_1, 9'b0100_0000_1, 9'b1001_1001_1,
                9'b0000_0000_0, 9'b0010_0010_0, 9'b0000_0000_1, 9'b1111_0110_1};
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        exp_y   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // 1: reset with all channels valid
        rst = 1'b1; x_valid = 4'b1111; X = 4'b1111; y_ready = 1'b1;
        cyc(); cyc();
        chk("rst_y_valid", int'(y_valid), 0);
        chk("rst_x_ready", int'(x_ready), 0);
        chk("rst_Y", int'(Y), 0);
        chk("rst_sel", int'(sel), 0);
        x_valid = 4'b0000;
        cyc();
        rst = 1'b0;

        // 2: single channel
        x_valid = 4'b0100; X = 4'b0100;
        #1 chk("single_x_ready", int'(x_ready), 4);
        cyc();
        chk("single_Y", int'(Y), 1);
        chk("single_sel", int'(sel), 2);
        chk("single_y_valid", int'(y_valid), 1);
        x_valid = 4'b0000;
        cyc();
        chk("single_drain", int'(y_valid), 0);

        // 3: fairness after a fresh reset
        rst = 1'b1; cyc(); rst = 1'b0;
        x_valid = 4'b1111; X = 4'b1010;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("fair_sel", int'(sel), int'(exp_sel[i]));
            chk("fair_Y", int'(Y), int'(exp_y[i]));
            chk("fair_y_valid", int'(y_valid), 1);
        end

        // 4: backpressure, ch3 held in output register
        y_ready = 1'b0;
        #1 chk("bp_x_ready_now", int'(x_ready), 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_sel", int'(sel), 3);
            chk("bp_Y", int'(Y), 1);
            chk("bp_y_valid", int'(y_valid), 1);
            chk("bp_x_ready", int'(x_ready), 0);
        end
        y_ready = 1'b1;
        #1 chk("bp_release_ready", int'(x_ready), 1);
        cyc();
        chk("bp_release_sel", int'(sel), 0);

        // 5: reset mid-stream with 3 channels active
        x_valid = 4'b1110; X = 4'b0110;
        cyc(); chk("mid_sel1", int'(sel), 1);
        cyc(); chk("mid_sel2", int'(sel), 2);
        cyc(); chk("mid_sel3", int'(sel), 3);
        rst = 1'b1;
        cyc();
        chk("mid_rst_y_valid", int'(y_valid), 0);
        rst = 1'b0; x_valid = 4'b1111;
        cyc();
        chk("mid_first_grant", int'(sel), 0);
        chk("mid_first_valid", int'(y_valid), 1);

        // directed vectors checked by the model
        for (int i = 0; i < 12; i++) begin
            x_valid = vec[i][8:5]; X = vec[i][4:1]; y_ready = vec[i][0];
            cyc();
        end

`ifdef MUX4_PKT_LOCK_EN
        // 6: packet lock, ch1 3-beat packet while ch0 stays valid
        x_valid = 4'b0000; y_ready = 1'b1;
        rst = 1'b1; cyc(); rst = 1'b0;
        x_valid = 4'b0001; x_last = 4'b0001; X = 4'b0000;
        cyc(); chk("pkt_pre_sel", int'(sel), 0);
        x_valid = 4'b0011; X = 4'b0010; x_last = 4'b0001;
        cyc(); chk("pkt_beat1", int'(sel), 1);
        cyc(); chk("pkt_beat2", int'(sel), 1);
        x_last = 4'b0011;
        cyc(); chk("pkt_beat3", int'(sel), 1);
        cyc(); chk("pkt_after", int'(sel), 0);
        x_last = 4'b1111;
`endif

        x_valid = 4'b0000;
        cyc(); cyc();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
